// File: rtl/resp_misr_capture.sv
// Response capture: folds each wide DUT output sample into a MISR signature,
// counts samples, compares against a golden value and drains the signature bytewise.
module resp_misr_capture #(
  parameter int               DATA_W = 127,
  parameter int               SIG_W  = 32,
  parameter logic [SIG_W-1:0] POLY   = 32'h04C11DB7,
  parameter logic [SIG_W-1:0] SEED   = 32'h00000000,
  parameter int               CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  input  logic              y_valid,
  input  logic [DATA_W-1:0] y,
  input  logic [SIG_W-1:0]  exp_sig,
  output logic              busy,
  output logic [CNT_W-1:0]  sample_cnt,
  output logic [SIG_W-1:0]  sig,
  output logic              match,
  output logic              done,
  output logic              ser_valid,
  input  logic              ser_ready,
  output logic [7:0]        ser_data
);

  localparam int NB    = SIG_W / 8;
  localparam int IDX_W = (NB > 1) ? $clog2(NB) : 1;
  localparam int NCH   = (DATA_W + SIG_W - 1) / SIG_W;
  localparam int PAD_W = NCH * SIG_W;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NB - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_DRAIN   = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [SIG_W-1:0]   sig_q, sig_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               match_q, match_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               ser_valid_q, ser_valid_d;
  logic [7:0]         ser_data_q, ser_data_d;
  logic [IDX_W-1:0]   idx_q, idx_d;

  function automatic logic [SIG_W-1:0] fold(input logic [DATA_W-1:0] v);
    logic [PAD_W-1:0] p;
    logic [SIG_W-1:0] r;
    p = PAD_W'(v);
    r = '0;
    for (int i = 0; i < NCH; i++) begin
      r = r ^ p[i*SIG_W +: SIG_W];
    end
    return r;
  endfunction

  function automatic logic [SIG_W-1:0] misr_step(input logic [SIG_W-1:0] s,
                                                 input logic [DATA_W-1:0] v);
    return {s[SIG_W-2:0], 1'b0} ^ (s[SIG_W-1] ? POLY : {SIG_W{1'b0}}) ^ fold(v);
  endfunction

  // Byte k of the signature counting from the most significant byte.
  function automatic logic [7:0] sig_byte(input logic [SIG_W-1:0] s,
                                          input logic [IDX_W-1:0] k);
    logic [SIG_W-1:0] sh;
    sh = s << {k, 3'b000};
    return sh[SIG_W-1 -: 8];
  endfunction

  always_comb begin
    state_d     = state_q;
    sig_d       = sig_q;
    cnt_d       = cnt_q;
    match_d     = match_q;
    idx_d       = idx_q;
    ser_valid_d = ser_valid_q;
    ser_data_d  = ser_data_q;
    done_d      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // done_q high means the drain finished this very cycle; start is not yet honoured
        if (start && !done_q) begin
          state_d = ST_CAPTURE;
          sig_d   = SEED;
          cnt_d   = '0;
          match_d = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CAPTURE: begin
        if (y_valid) begin
          sig_d = misr_step(sig_q, y);
          if (cnt_q != {CNT_W{1'b1}}) begin
            cnt_d = cnt_q + CNT_W'(1);
          end else begin
            cnt_d = cnt_q;
          end
        end else begin
          sig_d = sig_q;
        end
        if (stop) begin
          state_d     = ST_DRAIN;
          match_d     = (sig_d == exp_sig);
          idx_d       = '0;
          ser_valid_d = 1'b1;
          ser_data_d  = sig_byte(sig_d, '0);
        end else begin
          state_d = ST_CAPTURE;
        end
      end
      ST_DRAIN: begin
        if (ser_valid_q && ser_ready) begin
          if (idx_q == LAST_IDX) begin
            ser_valid_d = 1'b0;
            done_d      = 1'b1;
            state_d     = ST_IDLE;
          end else begin
            idx_d      = idx_q + IDX_W'(1);
            ser_data_d = sig_byte(sig_q, idx_q + IDX_W'(1));
          end
        end else begin
          state_d = ST_DRAIN;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        ser_valid_d = 1'b0;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      sig_q       <= SEED;
      cnt_q       <= '0;
      match_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      ser_valid_q <= 1'b0;
      ser_data_q  <= 8'h00;
      idx_q       <= '0;
    end else begin
      state_q     <= state_d;
      sig_q       <= sig_d;
      cnt_q       <= cnt_d;
      match_q     <= match_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      ser_valid_q <= ser_valid_d;
      ser_data_q  <= ser_data_d;
      idx_q       <= idx_d;
    end
  end

  assign busy       = busy_q;
  assign sample_cnt = cnt_q;
  assign sig        = sig_q;
  assign match      = match_q;
  assign done       = done_q;
  assign ser_valid  = ser_valid_q;
  assign ser_data   = ser_data_q;

endmodule

// File: tb/tb_resp_misr_capture.sv
// Directed + randomized bench for resp_misr_capture: three instances (default,
// seeded, narrow counter) share stimulus and are checked against a bit-level model.
module tb_resp_misr_capture;

  localparam logic [31:0] POLY_C = 32'h04C11DB7;
  localparam logic [31:0] SEED_A = 32'h00000000;
  localparam logic [31:0] SEED_B = 32'h80000000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n, start, stop, y_valid, ser_ready;
  logic [126:0] y;
  logic [31:0]  exp_sig;

  logic a_busy, a_match, a_done, a_sv;  logic [15:0] a_cnt; logic [31:0] a_sig; logic [7:0] a_sd;
  logic b_busy, b_match, b_done, b_sv;  logic [15:0] b_cnt; logic [31:0] b_sig; logic [7:0] b_sd;
  logic c_busy, c_match, c_done, c_sv;  logic [3:0]  c_cnt; logic [31:0] c_sig; logic [7:0] c_sd;

  resp_misr_capture u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .y_valid(y_valid), .y(y),
    .exp_sig(exp_sig), .busy(a_busy), .sample_cnt(a_cnt), .sig(a_sig), .match(a_match),
    .done(a_done), .ser_valid(a_sv), .ser_ready(ser_ready), .ser_data(a_sd));

  resp_misr_capture #(.SEED(SEED_B)) u_seed (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .y_valid(y_valid), .y(y),
    .exp_sig(exp_sig), .busy(b_busy), .sample_cnt(b_cnt), .sig(b_sig), .match(b_match),
    .done(b_done), .ser_valid(b_sv), .ser_ready(ser_ready), .ser_data(b_sd));

  resp_misr_capture #(.CNT_W(4)) u_sat (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .y_valid(y_valid), .y(y),
    .exp_sig(exp_sig), .busy(c_busy), .sample_cnt(c_cnt), .sig(c_sig), .match(c_match),
    .done(c_done), .ser_valid(c_sv), .ser_ready(ser_ready), .ser_data(c_sd));

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model state
  logic [31:0] ma, mb;
  int          mcnt;
  logic        ea, eb;

  // Each bit j of y lands on signature bit j mod 32 (zero-padded chunk XOR).
  function automatic logic [31:0] m_fold(input logic [126:0] v);
    logic [31:0] r = 32'h0;
    for (int j = 0; j < 127; j++) r[j % 32] = r[j % 32] ^ v[j];
    return r;
  endfunction

  // Polynomial multiply-by-x modulo x^32+POLY, then add the folded sample.
  function automatic logic [31:0] m_step(input logic [31:0] s, input logic [126:0] v);
    logic [32:0] t;
    t = {1'b0, s} * 33'd2;
    if (t[32]) t[31:0] = t[31:0] ^ POLY_C;
    return t[31:0] ^ m_fold(v);
  endfunction

  function automatic logic [7:0] bsel(input logic [31:0] s, input int k);
    logic [31:0] t;
    t = s >> (24 - 8 * k);
    return t[7:0];
  endfunction

  function automatic logic [126:0] rand_y();
    logic [127:0] t;
    t = {$urandom, $urandom, $urandom, $urandom};
    return t[126:0];
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp_v);
    n_assert++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_regs(input string tag);
    chk({tag, ".sigA"}, a_sig, ma);
    chk({tag, ".sigB"}, b_sig, mb);
    chk({tag, ".sigC"}, c_sig, ma);
    chk({tag, ".cntA"}, a_cnt, (mcnt > 65535) ? 65535 : mcnt);
    chk({tag, ".cntC"}, c_cnt, (mcnt > 15) ? 15 : mcnt);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, ".busy"}, {a_busy, b_busy, c_busy}, 3'b000);
    chk({tag, ".match"}, {a_match, b_match, c_match}, 3'b000);
    chk({tag, ".done"}, {a_done, b_done, c_done}, 3'b000);
    chk({tag, ".sv"}, {a_sv, b_sv, c_sv}, 3'b000);
    chk({tag, ".sd"}, {a_sd, b_sd, c_sd}, 24'h0);
    chk({tag, ".sigA"}, a_sig, SEED_A);
    chk({tag, ".sigB"}, b_sig, SEED_B);
    chk({tag, ".cnt"}, {a_cnt, b_cnt, c_cnt}, 36'h0);
  endtask

  task automatic model_reset();
    ma = SEED_A; mb = SEED_B; mcnt = 0;
  endtask

  task automatic begin_cap();
    start = 1'b1;
    tick();
    start = 1'b0;
    model_reset();
    chk("cap.busy", {a_busy, b_busy, c_busy}, 3'b111);
    chk("cap.match0", a_match, 1'b0);
    check_regs("cap.start");
  endtask

  task automatic sample(input logic [126:0] yin);
    y = yin; y_valid = 1'b1;
    tick();
    y_valid = 1'b0;
    ma = m_step(ma, yin); mb = m_step(mb, yin); mcnt++;
    check_regs("sample");
  endtask

  task automatic gap(input logic [126:0] yin);
    y = yin; y_valid = 1'b0;
    tick();
    check_regs("gap");
  endtask

  task automatic end_cap(input bit with_sample, input logic [126:0] yin, input bit good);
    if (with_sample) begin
      ma = m_step(ma, yin); mb = m_step(mb, yin); mcnt++;
    end
    exp_sig = good ? ma : (ma ^ 32'h1);
    stop = 1'b1; y_valid = with_sample; y = yin;
    tick();
    stop = 1'b0; y_valid = 1'b0;
    ea = (ma == exp_sig); eb = (mb == exp_sig);
    exp_sig = $urandom;   // exp_sig only matters on the stop cycle
    chk("stop.matchA", a_match, ea);
    chk("stop.matchB", b_match, eb);
    chk("stop.matchC", c_match, ea);
    chk("stop.busy", a_busy, 1'b1);
    chk("stop.sv", {a_sv, b_sv, c_sv}, 3'b111);
    check_regs("stop");
  endtask

  task automatic drain(input int stall_k, input int stall_n, input bit start_on_done);
    int k = 0, stalled = 0, cyc = 0;
    bit rdy;
    while (k < 4 && cyc < 200) begin
      chk("drain.sv", {a_sv, b_sv, c_sv}, 3'b111);
      chk("drain.sdA", a_sd, bsel(ma, k));
      chk("drain.sdB", b_sd, bsel(mb, k));
      chk("drain.sdC", c_sd, bsel(ma, k));
      chk("drain.early_done", {a_done, b_done, c_done}, 3'b000);
      rdy = !(k == stall_k && stalled < stall_n);
      if (!rdy) stalled++;
      ser_ready = rdy;
      tick();
      ser_ready = 1'b0;
      cyc++;
      if (rdy) k++;
    end
    chk("drain.bytes", k, 4);
    chk("drain.done", {a_done, b_done, c_done}, 3'b111);
    chk("drain.sv_low", {a_sv, b_sv, c_sv}, 3'b000);
    chk("drain.busy_low", {a_busy, b_busy, c_busy}, 3'b000);
    chk("drain.match_hold", {a_match, b_match}, {ea, eb});
    check_regs("drain.end");
    start = start_on_done;
    tick();
    start = 1'b0;
    chk("post.done", {a_done, b_done, c_done}, 3'b000);
    chk("post.busy", {a_busy, b_busy, c_busy}, 3'b000);
    check_regs("post");
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; y_valid = 1'b0; ser_ready = 1'b0;
    y = '0; exp_sig = 32'h0;
    model_reset();
    tick(); tick();
    check_reset_vals("reset");
    rst_n = 1'b1;
    tick();

    // Samples and stop in IDLE are ignored
    y = 127'h5; y_valid = 1'b1; stop = 1'b1;
    tick();
    y_valid = 1'b0; stop = 1'b0;
    check_reset_vals("idle_ignore");

    // Plan run: three y=1 samples, golden 7; a start mid-capture has no effect
    begin_cap();
    sample(127'h1);
    chk("plan.sig1", a_sig, 32'h1);
    start = 1'b1;
    sample(127'h1);
    start = 1'b0;
    chk("plan.sig3", a_sig, 32'h3);
    sample(127'h1);
    chk("plan.sig7", a_sig, 32'h7);
    end_cap(1'b0, '0, 1'b1);
    chk("plan.match", a_match, 1'b1);
    drain(-1, 0, 1'b0);

    // Mismatch run; start on the done cycle must be ignored
    begin_cap();
    repeat (3) sample(127'h1);
    end_cap(1'b0, '0, 1'b0);
    chk("plan.nomatch", a_match, 1'b0);
    drain(-1, 0, 1'b1);

    // Chunk 1 folds onto bit 0
    begin_cap();
    sample(127'h1_00000000);
    chk("plan.chunk1", a_sig, 32'h1);
    end_cap(1'b0, '0, 1'b1);
    drain(-1, 0, 1'b0);

    // Feedback on the seeded instance, with 5 cycles of backpressure on byte 1
    begin_cap();
    sample('0);
    chk("plan.poly", b_sig, 32'h04C11DB7);
    end_cap(1'b0, '0, 1'b1);
    chk("plan.byte0", b_sd, 8'h04);
    drain(1, 5, 1'b0);

    // Sample on the stop cycle is counted
    begin_cap();
    sample(rand_y());
    sample(rand_y());
    end_cap(1'b1, rand_y(), 1'b1);
    chk("stopsample.cnt", a_cnt, 16'd3);
    drain(-1, 0, 1'b0);

    // Counter saturation on the 4-bit instance
    begin_cap();
    for (int i = 0; i < 20; i++) sample(rand_y());
    chk("sat.cntC", c_cnt, 4'hF);
    chk("sat.cntA", a_cnt, 16'd20);
    end_cap(1'b0, '0, 1'b1);
    drain(2, 3, 1'b0);

    // Randomized captures with gaps and backpressure
    for (int r = 0; r < 8; r++) begin
      int n;
      begin_cap();
      n = $urandom_range(1, 12);
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 2) == 0) gap(rand_y());
        sample(rand_y());
      end
      end_cap($urandom_range(0, 1) == 1, rand_y(), $urandom_range(0, 1) == 1);
      drain($urandom_range(0, 3), $urandom_range(0, 4), $urandom_range(0, 1) == 1);
    end

    // Asynchronous reset while byte 1 is waiting
    begin_cap();
    sample(rand_y());
    sample(rand_y());
    end_cap(1'b0, '0, 1'b1);
    ser_ready = 1'b1;
    tick();
    ser_ready = 1'b0;
    chk("rst.byte1", a_sd, bsel(ma, 1));
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_reset_vals("rst.async");
    tick();
    check_reset_vals("rst.held");
    rst_n = 1'b1;
    tick();
    check_reset_vals("rst.released");

    // Fresh capture after reset
    begin_cap();
    for (int i = 0; i < 5; i++) sample(rand_y());
    end_cap(1'b1, rand_y(), 1'b1);
    drain(3, 2, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
